// File: rtl/det_sec_param_if.sv
// Serial detector bus: sample strobe and data bit in, lock/pulse/count status out.
interface det_sec_param_if #(
    parameter int LEN   = 5,
    parameter int CNT_W = 8
);
    logic             en;
    logic             s_in;
    logic             valido;
    logic             match_pulse;
    logic             rel_pulse;
    logic [CNT_W-1:0] cnt_match;
    logic [LEN-1:0]   sec_recibida;

    // Stimulus side: drives the serial line, observes status.
    modport master (
        output en, s_in,
        input  valido, match_pulse, rel_pulse, cnt_match, sec_recibida
    );

    // Detector side.
    modport slave (
        input  en, s_in,
        output valido, match_pulse, rel_pulse, cnt_match, sec_recibida
    );
endinterface

// File: rtl/det_sec_param.sv
// Parametrised serial sequence detector: locks on SECUENCIA, counts matches
// while locked, releases on SEC_REINICIO. All outputs are registered.
module det_sec_param #(
    parameter int             LEN          = 5,
    parameter logic [LEN-1:0] SECUENCIA    = 5'b10100,
    parameter logic [LEN-1:0] SEC_REINICIO = 5'b00000,
    parameter bit             OVERLAP      = 1'b1,
    parameter int             CNT_W        = 8
) (
    input  logic            clk,
    input  logic            rst,
    det_sec_param_if.slave  bus
);

    localparam int                FILL_W    = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

    // One-hot so that any other encoding is detectably illegal.
    typedef enum logic [1:0] {
        SEARCH = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic [LEN-1:0]    win, win_nxt, win_shift;
    logic [FILL_W-1:0] fill, fill_nxt, fill_upd;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              valido_q, valido_nxt;
    logic              match_q, match_nxt;
    logic              rel_q, rel_nxt;
    logic              cmp_ok, hit_sec, hit_rel;

    // Match counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Fill level counts received bits but never exceeds the window length.
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
        return (f >= FILL_FULL) ? FILL_FULL : f + 1'b1;
    endfunction

    // Candidate window/fill if the current bit is sampled.
    assign win_shift = {win[LEN-2:0], bus.s_in};
    assign fill_upd  = fill_inc(fill);
    assign cmp_ok    = (fill_upd == FILL_FULL);
    assign hit_sec   = cmp_ok && (win_shift == SECUENCIA);
    assign hit_rel   = cmp_ok && (win_shift == SEC_REINICIO);

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt = state;
        win_nxt   = win;
        fill_nxt  = fill;
        cnt_nxt   = cnt;
        match_nxt = 1'b0;
        rel_nxt   = 1'b0;
        case (state)
            SEARCH: begin
                if (bus.en) begin
                    win_nxt  = win_shift;
                    fill_nxt = fill_upd;
                    if (hit_sec) begin
                        match_nxt = 1'b1;
                        cnt_nxt   = sat_inc(cnt);
                        state_nxt = LOCKED;
                        // Release must be made of bits after the locking bit.
                        fill_nxt  = '0;
                    end
                end
            end
            LOCKED: begin
                if (bus.en) begin
                    win_nxt  = win_shift;
                    fill_nxt = fill_upd;
                    // Release wins when both patterns are identical.
                    if (hit_rel) begin
                        rel_nxt   = 1'b1;
                        state_nxt = SEARCH;
                        fill_nxt  = '0;
                    end else if (hit_sec) begin
                        match_nxt = 1'b1;
                        cnt_nxt   = sat_inc(cnt);
                        if (!OVERLAP) begin
                            fill_nxt = '0;
                        end
                    end
                end
            end
            default: begin
                // Illegal encoding: fall back to a clean search.
                state_nxt = SEARCH;
                fill_nxt  = '0;
            end
        endcase
        valido_nxt = (state_nxt == LOCKED);
    end

    // State, window, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            win      <= '0;
            fill     <= '0;
            cnt      <= '0;
            valido_q <= 1'b0;
            match_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            win      <= win_nxt;
            fill     <= fill_nxt;
            cnt      <= cnt_nxt;
            valido_q <= valido_nxt;
            match_q  <= match_nxt;
            rel_q    <= rel_nxt;
        end
    end

    assign bus.valido       = valido_q;
    assign bus.match_pulse  = match_q;
    assign bus.rel_pulse    = rel_q;
    assign bus.cnt_match    = cnt;
    assign bus.sec_recibida = win;

endmodule

// File: tb/tb_det_sec_param.sv
// Bench for det_sec_param: four parameterisations driven from one vector table.
module tb_det_sec_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst_v;

    det_sec_param_if #(.LEN(5), .CNT_W(8)) if0 ();
    det_sec_param_if #(.LEN(5), .CNT_W(8)) if1 ();
    det_sec_param_if #(.LEN(5), .CNT_W(8)) if2 ();
    det_sec_param_if #(.LEN(5), .CNT_W(2)) if3 ();

    det_sec_param u0 (.clk(clk), .rst(rst_v[0]), .bus(if0));
    det_sec_param #(.SECUENCIA(5'b10101), .OVERLAP(1'b1)) u1 (.clk(clk), .rst(rst_v[1]), .bus(if1));
    det_sec_param #(.SECUENCIA(5'b10101), .OVERLAP(1'b0)) u2 (.clk(clk), .rst(rst_v[2]), .bus(if2));
    det_sec_param #(.CNT_W(2)) u3 (.clk(clk), .rst(rst_v[3]), .bus(if3));

    typedef struct {
        int    d;
        bit    r;
        bit    e;
        bit    s;
        bit    v;
        bit    m;
        bit    rl;
        int    c;
        string tag;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(int d, bit r, bit e, bit s, bit v, bit m, bit rl, int c, string tag);
        vec_t t;
        t.d = d; t.r = r; t.e = e; t.s = s;
        t.v = v; t.m = m; t.rl = rl; t.c = c; t.tag = tag;
        tbl.push_back(t);
    endfunction

    // n enabled bits, MSB first; all but the last expect (pv,0,0,pc).
    function automatic void add_seq(int d, logic [7:0] bits, int n, bit pv, int pc,
                                    bit lv, bit lm, bit lr, int lc, string tag);
        for (int i = 0; i < n; i++) begin
            if (i < n - 1)
                add(d, 1'b0, 1'b1, bits[n-1-i], pv, 1'b0, 1'b0, pc, $sformatf("%s[%0d]", tag, i));
            else
                add(d, 1'b0, 1'b1, bits[n-1-i], lv, lm, lr, lc, $sformatf("%s[%0d]", tag, i));
        end
    endfunction

    task automatic drive(int d, bit r, bit e, bit s);
        rst_v = '0;
        if0.en = 1'b0; if1.en = 1'b0; if2.en = 1'b0; if3.en = 1'b0;
        if0.s_in = s; if1.s_in = s; if2.s_in = s; if3.s_in = s;
        rst_v[d] = r;
        case (d)
            0: if0.en = e;
            1: if1.en = e;
            2: if2.en = e;
            default: if3.en = e;
        endcase
    endtask

    task automatic sample(int d, output logic v, output logic m, output logic rl,
                          output logic [31:0] c, output logic [4:0] w);
        case (d)
            0: begin v = if0.valido; m = if0.match_pulse; rl = if0.rel_pulse; c = 32'(if0.cnt_match); w = if0.sec_recibida; end
            1: begin v = if1.valido; m = if1.match_pulse; rl = if1.rel_pulse; c = 32'(if1.cnt_match); w = if1.sec_recibida; end
            2: begin v = if2.valido; m = if2.match_pulse; rl = if2.rel_pulse; c = 32'(if2.cnt_match); w = if2.sec_recibida; end
            default: begin v = if3.valido; m = if3.match_pulse; rl = if3.rel_pulse; c = 32'(if3.cnt_match); w = if3.sec_recibida; end
        endcase
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Drive one vector at the falling edge, score it at the next falling edge.
    task automatic apply(vec_t v);
        vec_t        e;
        logic        av, am, ar;
        logic [31:0] ac;
        logic [4:0]  aw;
        drive(v.d, v.r, v.e, v.s);
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        sample(e.d, av, am, ar, ac, aw);
        check({e.tag, ".valido"},      32'(av), 32'(e.v));
        check({e.tag, ".match_pulse"}, 32'(am), 32'(e.m));
        check({e.tag, ".rel_pulse"},   32'(ar), 32'(e.rl));
        check({e.tag, ".cnt_match"},   ac,      32'(e.c));
    endtask

    initial begin
        logic        sv, sm, sr;
        logic [31:0] sc;
        logic [4:0]  sw;
        vec_t        hv;
        int          cprev;

        // Default detector: lock, idle, release, relock, prefix stream.
        add(0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, "t1_rst");
        add_seq(0, 8'b10100, 5, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1, "t1_lock");
        add(0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 1, "t1_pulse_end");
        add_seq(0, 8'b00000, 5, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1, "t3_rel");
        add(0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1, "t3_rel_end");
        add_seq(0, 8'b10100, 5, 1'b0, 1, 1'b1, 1'b1, 1'b0, 2, "t3_relock");
        add(0, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, "t1b_rst");
        add_seq(0, 8'b10110100, 8, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1, "t1_prefix");

        // Reset while locked with a partial fill.
        add(0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, "t6_rst");
        add_seq(0, 8'b10100, 5, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1, "t6_lock");
        add_seq(0, 8'b000, 3, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1, "t6_fill3");
        add(0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, "t6_rst_locked");
        add_seq(0, 8'b00000, 5, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, "t6_zeros");
        add_seq(0, 8'b10100, 5, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1, "t6_relock");

        // Pattern 10101 with overlap: two more matches in 1010101.
        add(1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, "t2o_rst");
        add_seq(1, 8'b10101, 5, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1, "t2o_lock");
        add_seq(1, 8'b1010, 4, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1, "t2o_head");
        add_seq(1, 8'b1, 1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 2, "t2o_m1");
        add_seq(1, 8'b0, 1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 2, "t2o_b6");
        add_seq(1, 8'b1, 1, 1'b1, 2, 1'b1, 1'b1, 1'b0, 3, "t2o_m2");

        // Same pattern without overlap: only one more match.
        add(2, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, "t2n_rst");
        add_seq(2, 8'b10101, 5, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1, "t2n_lock");
        add_seq(2, 8'b1010, 4, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1, "t2n_head");
        add_seq(2, 8'b1, 1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 2, "t2n_m1");
        add_seq(2, 8'b01, 2, 1'b1, 2, 1'b1, 1'b0, 1'b0, 2, "t2n_tail");

        // 2-bit counter saturates at 3 while pulses keep firing.
        add(3, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, "t5_rst");
        add_seq(3, 8'b10100, 5, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1, "t5_lock");
        cprev = 1;
        for (int k = 0; k < 5; k++) begin
            add_seq(3, 8'b10100, 5, 1'b1, cprev, 1'b1, 1'b1, 1'b0,
                    (cprev + 1 > 3) ? 3 : cprev + 1, $sformatf("t5_sat%0d", k));
            cprev = (cprev + 1 > 3) ? 3 : cprev + 1;
        end

        drive(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // en gating: three idle cycles with random data between each bit.
        hv.d = 0; hv.r = 1'b1; hv.e = 1'b0; hv.s = 1'b0;
        hv.v = 1'b0; hv.m = 1'b0; hv.rl = 1'b0; hv.c = 0; hv.tag = "t4_rst";
        apply(hv);
        for (int i = 0; i < 5; i++) begin
            hv.r = 1'b0; hv.e = 1'b1; hv.s = (i == 0 || i == 2);
            hv.v = (i == 4); hv.m = (i == 4); hv.c = (i == 4) ? 1 : 0;
            hv.tag = $sformatf("t4_bit%0d", i);
            apply(hv);
            if (i == 2) begin
                sample(0, sv, sm, sr, sc, sw);
                check("t4_window", 32'(sw), 32'(5'b00101));
            end
            for (int j = 0; j < 3; j++) begin
                hv.e = 1'b0; hv.s = 1'($urandom_range(0, 1)); hv.m = 1'b0;
                hv.tag = $sformatf("t4_idle%0d_%0d", i, j);
                apply(hv);
            end
        end
        sample(0, sv, sm, sr, sc, sw);
        check("t4_window_final", 32'(sw), 32'(5'b10100));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/det_sec_param.md
Name: det_sec_param

Overview:
Parametrised serial sequence detector and successor to the fixed 5-bit detector. It samples one bit per enabled clock into a LEN-bit window and compares the window against a configurable pattern. On a match it locks `valido` high and keeps counting further matches. It unlocks only when a configurable release sequence arrives. It sits on serial control/unlock lines and feeds status to the debug/register block.

Parameters:
LEN, 5, pattern length in bits (>=2).
SECUENCIA, 5'b10100, detect pattern, LEN bits; MSB is the first bit received.
SEC_REINICIO, 5'b00000, release pattern, LEN bits; MSB is the first bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = window fill cleared after every match.
CNT_W, 8, width of the match counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
en  in  1  sample strobe; s_in is consumed only when en=1.
s_in  in  1  serial data bit.
valido  out  1  registered; high while in LOCKED.
match_pulse  out  1  registered; 1-cycle pulse per SECUENCIA match.
rel_pulse  out  1  registered; 1-cycle pulse when the release sequence is accepted.
cnt_match  out  CNT_W  registered; saturating count of SECUENCIA matches.
sec_recibida  out  LEN  debug copy of the window; newest bit in LSB.

Behaviour:
- Reset: rst=1 at a rising edge gives state=SEARCH, window=0, fill=0, valido=0, match_pulse=0, rel_pulse=0, cnt_match=0. Reset overrides all other inputs, including mid-lock.
- Window: on an edge with en=1, nxt_win = {win[LEN-2:0], s_in} and fill = min(fill+1, LEN). fill width is $clog2(LEN+1).
- A comparison is valid only when the updated fill == LEN.
- en=0: window, fill, state and cnt_match hold; match_pulse and rel_pulse are 0 that cycle.
- Latency: all outputs update on the same edge that samples the completing bit. The pulse is visible for exactly one cycle after that edge.
- FSM, two states, one-hot encoded:
  - SEARCH: if nxt_win==SECUENCIA and fill is valid, then match_pulse=1, cnt_match++, go to LOCKED, clear fill. The window bits are kept for debug only.
  - LOCKED: valido=1.
    - If nxt_win==SEC_REINICIO and fill is valid: rel_pulse=1, go to SEARCH, clear fill.
    - Else if nxt_win==SECUENCIA and fill is valid: match_pulse=1, cnt_match++, stay in LOCKED.
    - Release has priority over the pattern when SECUENCIA==SEC_REINICIO.
- Entering LOCKED always clears fill. The release sequence must therefore consist of LEN bits received after the locking bit.
- OVERLAP=0: fill is cleared after every match in LOCKED, so the next match needs LEN fresh bits.
- OVERLAP=1: fill is retained and overlapping matches count.
- cnt_match saturates at 2^CNT_W-1; match_pulse still fires at saturation. The counter is cleared only by rst.
- valido goes low on the edge that accepts the release.
- Default states map to SEARCH with all outputs 0 (recovery from an illegal encoding).
- No combinational path from s_in to any output.

Test Plan:
1. Defaults, rst then en=1 with s_in=1,0,1,0,0 → after the 5th edge: match_pulse=1 for 1 cycle, valido=1, cnt_match=1. Prefix 1,0,1,1,0,1,0,0 → exactly one match.
2. SECUENCIA=5'b10101, stream 1,0,1,0,1,0,1 while LOCKED after a first lock:
   - OVERLAP=1 → 2 additional matches, cnt_match +2.
   - OVERLAP=0 → 1 additional match.
3. Release: after lock, send 0×4 → valido stays 1. 5th 0 → rel_pulse=1, valido=0. A further 1,0,1,0,0 relocks with cnt_match=2.
4. en gating: send 1,0,1,0,0 with en=0 for 3 cycles between each bit, s_in toggling randomly while en=0 → a single match, timed at the 5th enabled edge.
5. CNT_W=2: 5 matches while locked → cnt_match=3 (saturated), 5 match_pulses observed.
6. rst asserted for 1 cycle while LOCKED with fill=3 → next cycle valido=0 and cnt_match=0. Five zeros then produce no rel_pulse; 1,0,1,0,0 locks again.
